// File: rtl/mgmt_bus_master_pkg.sv
// Shared definitions for the management-bus master: FSM states, bus field
// widths and the default request timeout.
package mgmt_bus_master_pkg;

    localparam int ADR_W   = 32;
    localparam int DAT_W   = 32;
    localparam int WEN_W   = 2;
    localparam int CNT_W   = 8;
    localparam int TMO_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/mgmt_bus_master_if.sv
// Management bus between the upstream master and its NSLV slaves; the
// per-slave response lanes are packed side by side, slave i at [32i+31:32i].
interface mgmt_bus_master_if #(
    parameter int NSLV = 2
) ();
    import mgmt_bus_master_pkg::*;

    logic                    mgmt_req;
    logic [ADR_W-1:0]        mgmt_adr;
    logic                    mgmt_rwn;
    logic [WEN_W-1:0]        mgmt_wen;
    logic [DAT_W-1:0]        mgmt_txd;
    logic [NSLV-1:0]         mgmt_ack;
    logic [NSLV-1:0]         mgmt_rxe;
    logic [DAT_W*NSLV-1:0]   mgmt_rxd;

    modport master (
        output mgmt_req, mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd,
        input  mgmt_ack, mgmt_rxe, mgmt_rxd
    );

    modport slave (
        input  mgmt_req, mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd,
        output mgmt_ack, mgmt_rxe, mgmt_rxd
    );
endinterface

// File: rtl/mgmt_rsp_merge.sv
// Combines the slave response lanes: OR of read data from slaves flagging
// rxe, plus any-ack and more-than-one-ack detection.
module mgmt_rsp_merge
    import mgmt_bus_master_pkg::*;
#(
    parameter int NSLV = 2
) (
    input  logic [NSLV-1:0]       ack,
    input  logic [NSLV-1:0]       rxe,
    input  logic [DAT_W*NSLV-1:0] rxd,
    output logic [DAT_W-1:0]      dat,
    output logic                  any_ack,
    output logic                  multi_ack
);

    logic [NSLV-1:0][DAT_W-1:0] gated;

    genvar gi;
    generate
        for (gi = 0; gi < NSLV; gi++) begin : g_lane
            assign gated[gi] = rxd[gi*DAT_W +: DAT_W] & {DAT_W{rxe[gi]}};
        end
    endgenerate

    always_comb begin
        dat = '0;
        for (int i = 0; i < NSLV; i++) begin
            dat = dat | gated[i];
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign any_ack   = |ack;
    assign multi_ack = |(ack & (ack - NSLV'(1)));

endmodule

// File: rtl/mgmt_bus_master.sv
// Management-bus initiator: issues one core command at a time, waits for a
// slave ack or a timeout, returns one response strobe, then idles a cycle.
module mgmt_bus_master
    import mgmt_bus_master_pkg::*;
#(
    parameter int NSLV = 2,
    parameter int TMO  = TMO_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_vld,
    output logic                cmd_rdy,
    input  logic [ADR_W-1:0]    cmd_adr,
    input  logic                cmd_rwn,
    input  logic [WEN_W-1:0]    cmd_wen,
    input  logic [DAT_W-1:0]    cmd_wdat,
    output logic                rsp_vld,
    output logic [DAT_W-1:0]    rsp_dat,
    output logic                rsp_err,
    output logic                perf_sru,
    mgmt_bus_master_if.master   bus
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO - 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               req_reg;
    logic [ADR_W-1:0]   adr_reg;
    logic               rwn_reg;
    logic [WEN_W-1:0]   wen_reg;
    logic [DAT_W-1:0]   txd_reg;
    logic               rsp_vld_reg;
    logic [DAT_W-1:0]   rsp_dat_reg;
    logic               rsp_err_reg;
    logic               perf_reg;

    logic [DAT_W-1:0]   merge_dat;
    logic               any_ack;
    logic               multi_ack;

    mgmt_rsp_merge #(
        .NSLV (NSLV)
    ) u_merge (
        .ack       (bus.mgmt_ack),
        .rxe       (bus.mgmt_rxe),
        .rxd       (bus.mgmt_rxd),
        .dat       (merge_dat),
        .any_ack   (any_ack),
        .multi_ack (multi_ack)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            req_reg     <= 1'b0;
            adr_reg     <= '0;
            rwn_reg     <= 1'b1;
            wen_reg     <= '0;
            txd_reg     <= '0;
            rsp_vld_reg <= 1'b0;
            rsp_dat_reg <= '0;
            rsp_err_reg <= 1'b0;
            perf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_vld) begin
                        adr_reg   <= cmd_adr;
                        rwn_reg   <= cmd_rwn;
                        wen_reg   <= cmd_rwn ? '0 : cmd_wen;
                        txd_reg   <= cmd_wdat;
                        req_reg   <= 1'b1;
                        perf_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (cnt_reg != '1) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                    // An ack on the expiry cycle still counts as a normal response.
                    if (any_ack) begin
                        req_reg     <= 1'b0;
                        rsp_vld_reg <= 1'b1;
                        rsp_dat_reg <= rwn_reg ? merge_dat : '0;
                        rsp_err_reg <= multi_ack;
                        state_reg   <= ST_RSP;
                    end else if (cnt_reg == TMO_LAST) begin
                        req_reg     <= 1'b0;
                        rsp_vld_reg <= 1'b1;
                        rsp_dat_reg <= '0;
                        rsp_err_reg <= 1'b1;
                        state_reg   <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    rsp_vld_reg <= 1'b0;
                    rsp_dat_reg <= '0;
                    rsp_err_reg <= 1'b0;
                    perf_reg    <= 1'b0;
                    state_reg   <= ST_GAP;
                end
                ST_GAP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // The state register already reads IDLE while reset is held, so gate it.
    assign cmd_rdy      = rst && (state_reg == ST_IDLE);
    assign rsp_vld      = rsp_vld_reg;
    assign rsp_dat      = rsp_dat_reg;
    assign rsp_err      = rsp_err_reg;
    assign perf_sru     = perf_reg;
    assign bus.mgmt_req = req_reg;
    assign bus.mgmt_adr = adr_reg;
    assign bus.mgmt_rwn = rwn_reg;
    assign bus.mgmt_wen = wen_reg;
    assign bus.mgmt_txd = txd_reg;

endmodule

// File: tb/tb_mgmt_bus_master.sv
// Self-checking bench for mgmt_bus_master: table vectors, random transactions
// against a transaction-level model, and hand sequences for reset/back-to-back.
module tb_mgmt_bus_master;

    localparam int TMO  = 15;
    localparam int NSLV = 2;

    logic        clk;
    logic        rst;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [31:0] cmd_adr;
    logic        cmd_rwn;
    logic [1:0]  cmd_wen;
    logic [31:0] cmd_wdat;
    logic        rsp_vld;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        perf_sru;

    int checks   = 0;
    int failures = 0;

    mgmt_bus_master_if #(.NSLV(NSLV)) bus ();

    mgmt_bus_master #(
        .NSLV (NSLV),
        .TMO  (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .cmd_adr  (cmd_adr),
        .cmd_rwn  (cmd_rwn),
        .cmd_wen  (cmd_wen),
        .cmd_wdat (cmd_wdat),
        .rsp_vld  (rsp_vld),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .perf_sru (perf_sru),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] adr;
        logic        rwn;
        logic [1:0]  wen;
        logic [31:0] wdat;
        int          ack_dly;   // REQ cycle index in which slaves ack; -1 = never
        logic [1:0]  ack_mask;
        logic [1:0]  rxe_mask;
        logic [31:0] rxd0;
        logic [31:0] rxd1;
        int          late_at;   // extra ack injected at this cycle index; -1 = none
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_req;   // cycles mgmt_req is high
        logic [1:0]  exp_wen;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        bus.mgmt_ack = '0;
        bus.mgmt_rxe = '0;
        bus.mgmt_rxd = '0;
    endtask

    // Expected outcome of one transaction from the bus rules alone.
    function automatic void model(input logic rwn, input int d, input logic [1:0] am,
                                  input logic [1:0] em, input logic [31:0] r0,
                                  input logic [31:0] r1, output logic [31:0] dat,
                                  output logic err, output int nreq);
        if (am != 2'b00 && d >= 0 && d < TMO) begin
            nreq = d + 1;
            err  = ($countones(am) > 1);
            dat  = '0;
            if (rwn) begin
                if (em[0]) dat = dat | r0;
                if (em[1]) dat = dat | r1;
            end
        end else begin
            nreq = TMO;
            err  = 1'b1;
            dat  = '0;
        end
    endfunction

    task automatic run_txn(input vec_t v);
        int          wait_cnt = 0;
        int          n_rsp    = 0;
        int          n_req    = 0;
        logic        tl_bad   = 1'b0;
        logic        fld_bad  = 1'b0;
        logic [31:0] got_dat  = '0;
        logic        got_err  = 1'b0;

        while (!cmd_rdy && wait_cnt < 50) begin
            step();
            wait_cnt++;
        end
        chk({v.tag, ".rdy"}, 32'(cmd_rdy), 32'd1);

        cmd_vld  = 1'b1;
        cmd_adr  = v.adr;
        cmd_rwn  = v.rwn;
        cmd_wen  = v.wen;
        cmd_wdat = v.wdat;
        step();
        cmd_vld  = 1'b0;
        cmd_adr  = $urandom;
        cmd_rwn  = 1'($urandom);
        cmd_wen  = 2'($urandom);
        cmd_wdat = $urandom;

        for (int c = 0; c <= v.exp_req + 5; c++) begin
            if (bus.mgmt_req !== (c < v.exp_req))       tl_bad = 1'b1;
            if (perf_sru     !== (c <= v.exp_req))      tl_bad = 1'b1;
            if (rsp_vld      !== (c == v.exp_req))      tl_bad = 1'b1;
            if (cmd_rdy      !== (c >= v.exp_req + 2))  tl_bad = 1'b1;
            if (bus.mgmt_req) begin
                n_req++;
                if (bus.mgmt_adr !== v.adr || bus.mgmt_rwn !== v.rwn ||
                    bus.mgmt_wen !== v.exp_wen || bus.mgmt_txd !== v.wdat)
                    fld_bad = 1'b1;
            end
            if (rsp_vld) begin
                n_rsp++;
                got_dat = rsp_dat;
                got_err = rsp_err;
            end
            if (c == v.ack_dly || c == v.late_at) begin
                bus.mgmt_ack = v.ack_mask;
                bus.mgmt_rxe = v.rxe_mask;
                bus.mgmt_rxd = {v.rxe_mask[1] ? v.rxd1 : 32'h0,
                                v.rxe_mask[0] ? v.rxd0 : 32'h0};
            end else begin
                slave_idle();
            end
            step();
        end
        slave_idle();

        chk({v.tag, ".timeline"}, 32'(tl_bad), 32'd0);
        chk({v.tag, ".fields"},   32'(fld_bad), 32'd0);
        chk({v.tag, ".req_cyc"},  32'(n_req), 32'(v.exp_req));
        chk({v.tag, ".n_rsp"},    32'(n_rsp), 32'd1);
        chk({v.tag, ".rsp_dat"},  got_dat, v.exp_dat);
        chk({v.tag, ".rsp_err"},  32'(got_err), 32'(v.exp_err));
        $display("txn %s adr=%08h rwn=%0d req_cycles=%0d rsp_dat=%08h rsp_err=%0d",
                 v.tag, v.adr, v.rwn, n_req, got_dat, got_err);
    endtask

    initial begin
        vec_t rv;
        int   rises, pulses, low_run, min_low, run;
        logic prev_req, bad_rdy, prev_rsp;
        int   rst_rsp;

        vecs[0] = '{"rd_s0",    32'h5,        1'b1, 2'b00, 32'h0,    3, 2'b01, 2'b01, 32'h1234ABCD, 32'h0,   -1, 32'h1234ABCD, 1'b0, 4,  2'b00};
        vecs[1] = '{"wr_wen01", 32'h2,        1'b0, 2'b01, 32'hDEAD, 3, 2'b01, 2'b00, 32'h0,        32'h0,   -1, 32'h0,        1'b0, 4,  2'b01};
        vecs[2] = '{"rd_wen11", 32'h10,       1'b1, 2'b11, 32'hBEEF, 3, 2'b01, 2'b01, 32'h55,       32'h0,   -1, 32'h55,       1'b0, 4,  2'b00};
        vecs[3] = '{"timeout",  32'hFFFF0000, 1'b1, 2'b00, 32'h0,   -1, 2'b01, 2'b01, 32'h99,       32'h0,   17, 32'h0,        1'b1, 15, 2'b00};
        vecs[4] = '{"multi",    32'h8,        1'b1, 2'b00, 32'h0,    3, 2'b11, 2'b11, 32'h0F0,      32'h00F, -1, 32'h0FF,      1'b1, 4,  2'b00};
        vecs[5] = '{"ack_last", 32'h20,       1'b1, 2'b00, 32'h0,   14, 2'b10, 2'b10, 32'h0,        32'hCAFE,-1, 32'hCAFE,     1'b0, 15, 2'b00};
        vecs[6] = '{"wr_rxd",   32'h30,       1'b0, 2'b10, 32'h1357, 1, 2'b10, 2'b10, 32'h0,        32'h77,  -1, 32'h0,        1'b0, 2,  2'b10};
        vecs[7] = '{"rd_d0",    32'h40,       1'b1, 2'b00, 32'h0,    0, 2'b01, 2'b01, 32'hA5,       32'h0,   -1, 32'hA5,       1'b0, 1,  2'b00};

        rst      = 1'b0;
        cmd_vld  = 1'b0;
        cmd_adr  = '0;
        cmd_rwn  = 1'b0;
        cmd_wen  = '0;
        cmd_wdat = '0;
        slave_idle();
        step();
        step();
        chk("rst.cmd_rdy",  32'(cmd_rdy), 32'd0);
        chk("rst.mgmt_req", 32'(bus.mgmt_req), 32'd0);
        chk("rst.mgmt_adr", bus.mgmt_adr, 32'd0);
        chk("rst.mgmt_txd", bus.mgmt_txd, 32'd0);
        chk("rst.mgmt_rwn", 32'(bus.mgmt_rwn), 32'd1);
        chk("rst.mgmt_wen", 32'(bus.mgmt_wen), 32'd0);
        chk("rst.rsp_vld",  32'(rsp_vld), 32'd0);
        chk("rst.rsp_dat",  rsp_dat, 32'd0);
        chk("rst.rsp_err",  32'(rsp_err), 32'd0);
        chk("rst.perf_sru", 32'(perf_sru), 32'd0);
        rst = 1'b1;
        step();
        chk("post_rst.cmd_rdy", 32'(cmd_rdy), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i]);
        end

        // Back-to-back: cmd_vld held high across two commands.
        cmd_vld  = 1'b1;
        cmd_adr  = 32'h44;
        cmd_rwn  = 1'b1;
        cmd_wen  = 2'b00;
        cmd_wdat = '0;
        rises = 0; pulses = 0; low_run = 0; min_low = 99; run = 0;
        prev_req = 1'b0; prev_rsp = 1'b0; bad_rdy = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.mgmt_req && !prev_req) begin
                rises++;
                if (rises > 1 && low_run < min_low) min_low = low_run;
                if (rises == 2) cmd_vld = 1'b0;
                run = 0;
            end
            if (bus.mgmt_req) low_run = 0;
            else              low_run++;
            if (rsp_vld) begin
                pulses++;
                if (rsp_dat !== 32'h600D) bad_rdy = 1'b1;
            end
            if (cmd_rdy && (bus.mgmt_req || rsp_vld || prev_rsp)) bad_rdy = 1'b1;
            if (bus.mgmt_req && run == 3) begin
                bus.mgmt_ack = 2'b01;
                bus.mgmt_rxe = 2'b01;
                bus.mgmt_rxd = {32'h0, 32'h600D};
            end else begin
                slave_idle();
            end
            if (bus.mgmt_req) run++;
            prev_req = bus.mgmt_req;
            prev_rsp = rsp_vld;
            step();
        end
        cmd_vld = 1'b0;
        slave_idle();
        chk("b2b.rises",   32'(rises), 32'd2);
        chk("b2b.pulses",  32'(pulses), 32'd2);
        chk("b2b.gap_ok",  32'(min_low >= 1 && min_low < 99), 32'd1);
        chk("b2b.rdy_dat", 32'(bad_rdy), 32'd0);
        $display("txn b2b rises=%0d rsp_pulses=%0d min_low=%0d", rises, pulses, min_low);

        // Reset asserted while a read is in REQ.
        cmd_vld = 1'b1;
        cmd_adr = 32'h123;
        cmd_rwn = 1'b1;
        step();
        cmd_vld = 1'b0;
        step();
        step();
        chk("mid.req_before", 32'(bus.mgmt_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid.req_async", 32'(bus.mgmt_req), 32'd0);
        bus.mgmt_ack = 2'b01;
        bus.mgmt_rxe = 2'b01;
        bus.mgmt_rxd = {32'h0, 32'hBAD0BAD0};
        step();
        chk("mid.mgmt_req", 32'(bus.mgmt_req), 32'd0);
        chk("mid.perf_sru", 32'(perf_sru), 32'd0);
        chk("mid.cmd_rdy",  32'(cmd_rdy), 32'd0);
        chk("mid.mgmt_adr", bus.mgmt_adr, 32'd0);
        chk("mid.mgmt_rwn", 32'(bus.mgmt_rwn), 32'd1);
        rst_rsp = 0;
        for (int c = 0; c < 3; c++) begin
            if (rsp_vld) rst_rsp++;
            step();
        end
        slave_idle();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (rsp_vld) rst_rsp++;
            step();
        end
        chk("mid.no_rsp", 32'(rst_rsp), 32'd0);
        $display("txn rst_abort adr=00000123 rsp_pulses=%0d", rst_rsp);
        run_txn('{"after_rst", 32'h7, 1'b1, 2'b00, 32'h0, 3, 2'b01, 2'b01, 32'h0BADF00D, 32'h0,
                  -1, 32'h0BADF00D, 1'b0, 4, 2'b00});

        // Random transactions against the transaction-level model.
        for (int i = 0; i < 40; i++) begin
            rv.tag      = $sformatf("rnd%0d", i);
            rv.adr      = $urandom;
            rv.rwn      = 1'($urandom);
            rv.wen      = 2'($urandom);
            rv.wdat     = $urandom;
            rv.ack_dly  = int'($urandom_range(0, TMO + 3));
            rv.ack_mask = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            rv.rxe_mask = rv.ack_mask & 2'($urandom_range(0, 3));
            rv.rxd0     = $urandom;
            rv.rxd1     = $urandom;
            rv.late_at  = -1;
            rv.exp_wen  = rv.rwn ? 2'b00 : rv.wen;
            model(rv.rwn, rv.ack_dly, rv.ack_mask, rv.rxe_mask, rv.rxd0, rv.rxd1,
                  rv.exp_dat, rv.exp_err, rv.exp_req);
            run_txn(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
